// File: rtl/tqvp_pwm_pkg.sv
// Shared register map and bit positions for the multi-channel PWM peripheral.
package tqvp_pwm_pkg;
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_POL    = 4'h1;
  localparam logic [3:0] ADDR_PERIOD = 4'h2;
  localparam logic [3:0] ADDR_PRESC  = 4'h3;
  localparam logic [3:0] ADDR_DUTY0  = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'hC;
  localparam logic [3:0] ADDR_CNT    = 4'hD;
  localparam logic [3:0] ADDR_UI     = 4'hE;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_CLR     = 2;
  localparam int STAT_EN      = 0;
  localparam int STAT_WRAP    = 1;

  localparam logic [7:0] PERIOD_RST = 8'hFF;
endpackage

// File: rtl/tqvp_pwm_channel.sv
// One PWM lane: double-buffered duty, compare against the shared counter,
// polarity invert and output register.
module tqvp_pwm_channel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cnt,
  input  logic       en,
  input  logic       load,
  input  logic       wr,
  input  logic [7:0] data,
  input  logic       pol,
  output logic [7:0] duty_sh,
  output logic       pwm
);
  logic [7:0] duty_act;

  // Shadow takes writes; active reloads on load, with a same-edge write passed straight through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_sh  <= 8'h00;
      duty_act <= 8'h00;
      pwm      <= 1'b0;
    end else begin
      if (wr)   duty_sh  <= data;
      if (load) duty_act <= wr ? data : duty_sh;
      pwm <= (en && (cnt < duty_act)) ^ pol;
    end
  end
endmodule

// File: rtl/tqvp_byte_pwm_multi.sv
// Multi-channel PWM byte peripheral: shared prescaler and period counter,
// per-channel duty lanes, register file and combinational read mux.
module tqvp_byte_pwm_multi
  import tqvp_pwm_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  logic                     en, oneshot, wrap;
  logic [CHANNELS-1:0]      pol;
  logic [7:0]               period_sh, period_act, prescale, pcnt, cnt;
  logic [CHANNELS-1:0]      pwm;
  logic [CHANNELS-1:0][7:0] duty_sh;

  logic wr_ctrl, wr_period, clr, tick, wrap_ev, load;

  assign wr_ctrl   = data_write && (address == ADDR_CTRL);
  assign wr_period = data_write && (address == ADDR_PERIOD);
  assign clr       = wr_ctrl && data_in[CTRL_CLR];
  assign tick      = en && (pcnt == prescale);
  // CLR suppresses a coincident wrap so it never sets WRAP or drops EN.
  assign wrap_ev   = tick && (cnt == period_act) && !clr;
  // Actives track shadows while stopped, and reload on wrap or CLR.
  assign load      = !en || clr || wrap_ev;

  // Control, status and shadow registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en         <= 1'b0;
      oneshot    <= 1'b0;
      wrap       <= 1'b0;
      pol        <= '0;
      period_sh  <= PERIOD_RST;
      period_act <= 8'h00;
      prescale   <= 8'h00;
    end else begin
      if (wr_ctrl) begin
        en      <= data_in[CTRL_EN];
        oneshot <= data_in[CTRL_ONESHOT];
      end else if (wrap_ev && oneshot) begin
        en <= 1'b0;
      end
      if (wrap_ev)
        wrap <= 1'b1;
      else if (data_write && address == ADDR_STATUS && data_in[STAT_WRAP])
        wrap <= 1'b0;
      if (data_write && address == ADDR_POL)   pol      <= data_in[CHANNELS-1:0];
      if (data_write && address == ADDR_PRESC) prescale <= data_in;
      if (wr_period) period_sh <= data_in;
      if (load)      period_act <= wr_period ? data_in : period_sh;
    end
  end

  // Prescaler and period counter; both parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !en || clr) begin
      pcnt <= 8'h00;
      cnt  <= 8'h00;
    end else begin
      pcnt <= tick ? 8'h00 : pcnt + 8'h01;
      if (wrap_ev)   cnt <= 8'h00;
      else if (tick) cnt <= cnt + 8'h01;
    end
  end

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [3:0] DUTY_ADDR = ADDR_DUTY0 + 4'(i);
      tqvp_pwm_channel u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt     (cnt),
        .en      (en),
        .load    (load),
        .wr      (data_write && (address == DUTY_ADDR)),
        .data    (data_in),
        .pol     (pol[i]),
        .duty_sh (duty_sh[i]),
        .pwm     (pwm[i])
      );
    end
  endgenerate

  // Unused upper pins stay low.
  always_comb begin
    uo_out = 8'h00;
    uo_out[CHANNELS-1:0] = pwm;
  end

  // Zero-latency read mux; unmapped addresses return 0.
  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CTRL:   data_out = {6'b0, oneshot, en};
      ADDR_POL:    data_out = 8'(pol);
      ADDR_PERIOD: data_out = period_sh;
      ADDR_PRESC:  data_out = prescale;
      ADDR_STATUS: data_out = {6'b0, wrap, en};
      ADDR_CNT:    data_out = cnt;
      ADDR_UI:     data_out = ui_in;
      default: begin
        for (int k = 0; k < CHANNELS; k++)
          if (address == 4'(ADDR_DUTY0 + k)) data_out = duty_sh[k];
      end
    endcase
  end
endmodule

// File: tb/tb_tqvp_byte_pwm_multi.sv
// Directed bench for tqvp_byte_pwm_multi (CHANNELS = 4).
module tb_tqvp_byte_pwm_multi;
  import tqvp_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int failures = 0;

  tqvp_byte_pwm_multi #(.CHANNELS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
    end
  endtask

  // Write lands on the posedge between the two negedges.
  task wr_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    address = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  initial begin
    rst_n = 1'b0; ui_in = 8'hA5; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state
    chk("rst_uo", uo_out, 8'h00);
    rd_chk("rst_period", ADDR_PERIOD, 8'hFF);
    rd_chk("rst_cnt", ADDR_CNT, 8'h00);
    rd_chk("rst_ctrl", ADDR_CTRL, 8'h00);
    rd_chk("rst_ui", ADDR_UI, 8'hA5);
    rd_chk("rst_unmapped", 4'h9, 8'h00);

    // 2: basic duties, period 4, no prescale
    wr_reg(ADDR_PERIOD, 8'd3);
    wr_reg(ADDR_PRESC, 8'd0);
    wr_reg(ADDR_DUTY0, 8'd2);
    wr_reg(ADDR_DUTY0 + 4'd1, 8'd0);
    wr_reg(ADDR_DUTY0 + 4'd2, 8'd4);
    rd_chk("duty2_rd", ADDR_DUTY0 + 4'd2, 8'd4);
    rd_chk("stat_prewrap", ADDR_STATUS, 8'h00);
    wr_reg(ADDR_CTRL, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t2_uo_%0d", k), uo_out, (((k - 1) % 4) < 2) ? 8'h05 : 8'h04);
      rd_chk($sformatf("t2_cnt_%0d", k), ADDR_CNT, 8'(k % 4));
    end
    rd_chk("t2_status", ADDR_STATUS, 8'h03);
    wr_reg(ADDR_CTRL, 8'h00);
    wr_reg(ADDR_STATUS, 8'h02);
    rd_chk("t2_stat_clr", ADDR_STATUS, 8'h00);

    // 3: duty change mid-period only applies after wrap
    wr_reg(ADDR_PERIOD, 8'd9);
    wr_reg(ADDR_DUTY0, 8'd5);
    wr_reg(ADDR_CTRL, 8'h01);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4) data_write = 1'b0;
      chk($sformatf("t3_uo0_%0d", k), {7'b0, uo_out[0]},
          {7'b0, (((k - 1) % 10) < ((k <= 10) ? 5 : 2))});
      if (k == 3) begin
        address = ADDR_DUTY0; data_in = 8'd2; data_write = 1'b1;
      end
    end
    wr_reg(ADDR_CTRL, 8'h00);

    // 4: prescale 2, period 1
    wr_reg(ADDR_PRESC, 8'd2);
    wr_reg(ADDR_PERIOD, 8'd1);
    wr_reg(ADDR_CTRL, 8'h01);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      rd_chk($sformatf("t4_cnt_%0d", k), ADDR_CNT, 8'((k / 3) % 2));
    end
    wr_reg(ADDR_CTRL, 8'h00);
    wr_reg(ADDR_PRESC, 8'd0);
    wr_reg(ADDR_STATUS, 8'h02);

    // 5: one-shot
    wr_reg(ADDR_PERIOD, 8'd3);
    wr_reg(ADDR_DUTY0, 8'd1);
    wr_reg(ADDR_CTRL, 8'h03);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t5_uo0_%0d", k), {7'b0, uo_out[0]}, (k == 1) ? 8'h01 : 8'h00);
    end
    chk("t5_uo_idle", uo_out, 8'h00);
    rd_chk("t5_status", ADDR_STATUS, 8'h02);
    rd_chk("t5_ctrl", ADDR_CTRL, 8'h02);
    rd_chk("t5_cnt", ADDR_CNT, 8'h00);
    wr_reg(ADDR_STATUS, 8'h02);
    rd_chk("t5_stat_clr", ADDR_STATUS, 8'h00);

    // 6: polarity, then CLR mid-period
    wr_reg(ADDR_CTRL, 8'h00);
    wr_reg(ADDR_POL, 8'h01);
    @(negedge clk);
    chk("t6_pol_uo", uo_out, 8'h01);
    rd_chk("t6_pol_rd", ADDR_POL, 8'h01);
    wr_reg(ADDR_PERIOD, 8'd9);
    wr_reg(ADDR_CTRL, 8'h01);
    for (int k = 1; k <= 6; k++) @(negedge clk);
    rd_chk("t6_cnt6", ADDR_CNT, 8'd6);
    address = ADDR_CTRL; data_in = 8'h05; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    rd_chk("t6_cnt_clr", ADDR_CNT, 8'h00);
    rd_chk("t6_status", ADDR_STATUS, 8'h01);
    rd_chk("t6_ctrl", ADDR_CTRL, 8'h01);

    // Reset mid-operation
    wr_reg(ADDR_PERIOD, 8'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_uo", uo_out, 8'h00);
    rd_chk("mrst_period", ADDR_PERIOD, 8'hFF);
    rd_chk("mrst_ctrl", ADDR_CTRL, 8'h00);
    rd_chk("mrst_pol", ADDR_POL, 8'h00);
    rd_chk("mrst_duty0", ADDR_DUTY0, 8'h00);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
